ps2_cmd_ctrl: RTL and testbench

//  Command sequencer and RX-port arbiter for the PS/2 core (TX unit + RX unit + RX FIFO).

---
 rtl/ps2_ctrl_pkg.sv | 25 ++
 rtl/ps2_cmd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_ctrl_pkg.sv
// rtl/ps2_ctrl_pkg.sv - shared states, error codes and device reply bytes for the PS/2 command controller
package ps2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TX_START,
    TX_DONE,
    WAIT_RX,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_RETRY   = 2'b10,
    ERR_DEVICE  = 2'b11
  } err_t;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_DEV_ERR = 8'hFC;

endpackage

// File: rtl/ps2_cmd_ctrl.sv
// rtl/ps2_cmd_ctrl.sv - PS/2 command sequencer with ACK/RESEND handling, timeout and RX FIFO arbitration
module ps2_cmd_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_busy,
  output logic       cmd_done_tick,
  output logic       cmd_err,
  output logic [1:0] err_code,
  output logic       wr_ps2,
  output logic [7:0] ps2_tx_data,
  input  logic       ps2_tx_idle,
  input  logic [7:0] ps2_rx_data,
  input  logic       ps2_rx_buf_empty,
  output logic       rd_ps2_packet,
  input  logic       host_rd,
  output logic [7:0] host_rx_data,
  output logic       host_rx_empty
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY);

  state_t        state, next_state;
  err_t          err_q, err_next;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [7:0]    arg_q;
  logic          has_arg_q;
  logic          arg_phase;
  logic          rx_valid;
  logic          in_wait;
  logic          timed_out;
  logic          load_arg;
  logic          bump_retry;

  assign rx_valid  = (state == WAIT_RX) && !ps2_rx_buf_empty;
  assign in_wait   = (state == TX_START) || (state == TX_DONE) || (state == WAIT_RX);
  assign timed_out = in_wait && (timer == T_LAST);
  assign err_code  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_next   = ERR_NONE;
    load_arg   = 1'b0;
    bump_retry = 1'b0;
    case (state)
      IDLE:     if (cmd_start) next_state = SEND;
      SEND:     next_state = TX_START;
      TX_START: begin
        if (!ps2_tx_idle) next_state = TX_DONE;
        else if (timed_out) begin
          next_state = ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      TX_DONE: begin
        if (ps2_tx_idle) next_state = WAIT_RX;
        else if (timed_out) begin
          next_state = ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      WAIT_RX: begin
        if (timed_out) begin
          next_state = ERR;
          err_next   = ERR_TIMEOUT;
        end
        // A recognised reply in the same cycle as the timeout still wins
        if (rx_valid) begin
          if (ps2_rx_data == PS2_ACK) begin
            err_next = ERR_NONE;
            if (!arg_phase && has_arg_q) begin
              next_state = SEND;
              load_arg   = 1'b1;
            end else begin
              next_state = DONE;
            end
          end else if (ps2_rx_data == PS2_RESEND) begin
            if (retry == R_LAST) begin
              next_state = ERR;
              err_next   = ERR_RETRY;
            end else begin
              next_state = SEND;
              err_next   = ERR_NONE;
              bump_retry = 1'b1;
            end
          end else if (ps2_rx_data == PS2_DEV_ERR) begin
            next_state = ERR;
            err_next   = ERR_DEVICE;
          end
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_busy      = (state != IDLE);
    wr_ps2        = (state == SEND);
    cmd_done_tick = (state == DONE) || (state == ERR);
    rd_ps2_packet = rx_valid || (host_rd && !ps2_rx_buf_empty && (state == IDLE));
    host_rx_data  = ps2_rx_data;
    host_rx_empty = ps2_rx_buf_empty || (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2_tx_data <= 8'h00;
      arg_q       <= 8'h00;
      has_arg_q   <= 1'b0;
      arg_phase   <= 1'b0;
      retry       <= '0;
      timer       <= '0;
      cmd_err     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      if ((state == IDLE) && cmd_start) begin
        ps2_tx_data <= cmd_byte;
        arg_q       <= cmd_arg;
        has_arg_q   <= cmd_has_arg;
        arg_phase   <= 1'b0;
        retry       <= '0;
        cmd_err     <= 1'b0;
        err_q       <= ERR_NONE;
      end
      if (load_arg) begin
        ps2_tx_data <= arg_q;
        arg_phase   <= 1'b1;
        retry       <= '0;
      end
      if (bump_retry) retry <= retry + RW'(1);
      if ((next_state == ERR) && (state != ERR)) begin
        cmd_err <= 1'b1;
        err_q   <= err_next;
      end
      // Every state change restarts the wait budget; the count holds at its last value
      if (next_state != state) timer <= '0;
      else if (in_wait && !timed_out) timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb/tb_ps2_cmd_ctrl.sv - bench for ps2_cmd_ctrl with PS/2 device, TX unit and RX FIFO models
module tb_ps2_cmd_ctrl;

  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_RETRY   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_start;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       cmd_busy;
  logic       cmd_done_tick;
  logic       cmd_err;
  logic [1:0] err_code;
  logic       wr_ps2;
  logic [7:0] ps2_tx_data;
  logic       ps2_tx_idle;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_buf_empty;
  logic       rd_ps2_packet;
  logic       host_rd;
  logic [7:0] host_rx_data;
  logic       host_rx_empty;

  ps2_cmd_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .cmd_busy(cmd_busy), .cmd_done_tick(cmd_done_tick), .cmd_err(cmd_err), .err_code(err_code),
    .wr_ps2(wr_ps2), .ps2_tx_data(ps2_tx_data), .ps2_tx_idle(ps2_tx_idle),
    .ps2_rx_data(ps2_rx_data), .ps2_rx_buf_empty(ps2_rx_buf_empty), .rd_ps2_packet(rd_ps2_packet),
    .host_rd(host_rd), .host_rx_data(host_rx_data), .host_rx_empty(host_rx_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int last_idle_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] reply_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] script[$];
  logic [7:0] exp_tx[$];

  // Device side: TX unit goes busy shortly after each write, and when it finishes
  // the device answers with the next scripted reply pushed into the RX FIFO.
  initial begin : dev_model
    logic       do_pop, do_wr;
    logic [7:0] wr_b, rep_b;
    int         tx_wait, tx_busy, rep_wait;
    tx_wait = 0; tx_busy = 0; rep_wait = -1; rep_b = 8'h00;
    ps2_tx_idle = 1'b1; ps2_rx_buf_empty = 1'b1; ps2_rx_data = 8'h00;
    forever begin
      @(negedge clk); #2;
      do_pop = rd_ps2_packet && !ps2_rx_buf_empty;
      do_wr  = wr_ps2;
      wr_b   = ps2_tx_data;
      @(posedge clk); #1;
      cyc++;
      if (do_pop && rx_q.size() > 0) begin
        rx_q.delete(0);
        pop_cnt++;
      end
      if (do_wr) begin
        tx_log.push_back(wr_b);
        tx_wait = $urandom_range(1, 3);
      end else if (tx_wait > 0) begin
        tx_wait--;
        if (tx_wait == 0) begin
          ps2_tx_idle = 1'b0;
          tx_busy = $urandom_range(4, 12);
        end
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) begin
          ps2_tx_idle = 1'b1;
          last_idle_cyc = cyc;
          if (reply_q.size() > 0) begin
            rep_b = reply_q.pop_front();
            rep_wait = $urandom_range(0, 4);
          end
        end
      end
      if (rep_wait == 0) begin
        rx_q.push_back(rep_b);
        rep_wait = -1;
      end else if (rep_wait > 0) begin
        rep_wait--;
      end
      ps2_rx_buf_empty = (rx_q.size() == 0);
      ps2_rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic run_cmd(input string tag, input logic [7:0] op, input logic has_arg,
                         input logic [7:0] arg, input int n_stale, input bit hold_host,
                         input bit host_at_start);
    logic [1:0] exp_err;
    logic [7:0] cur, r;
    int         used, retries, pops0, exp_pops, waited, bad;
    bit         arg_ph, fin, got_done;
    // Reference: each write consumes one device reply in order
    exp_tx.delete();
    exp_err = 2'b00; used = 0; retries = 0; cur = op; arg_ph = 0; fin = 0;
    while (!fin) begin
      exp_tx.push_back(cur);
      if (used >= script.size()) begin
        exp_err = 2'b01; fin = 1;
      end else begin
        r = script[used]; used++;
        if (r == 8'hFA) begin
          if (!arg_ph && has_arg) begin arg_ph = 1; cur = arg; retries = 0; end
          else fin = 1;
        end else if (r == 8'hFE) begin
          if (retries == MAX_RETRY) begin exp_err = 2'b10; fin = 1; end
          else retries++;
        end else begin
          exp_err = 2'b11; fin = 1;
        end
      end
    end
    exp_pops = used + n_stale + (host_at_start ? 1 : 0);

    pops0 = pop_cnt;
    tx_log.delete();
    reply_q = script;
    for (int i = 0; i < n_stale; i++) rx_q.push_back(8'($urandom_range(0, 8'hF0)));
    @(negedge clk);
    cmd_byte = op; cmd_has_arg = has_arg; cmd_arg = arg; cmd_start = 1'b1; host_rd = host_at_start;
    @(negedge clk);
    cmd_start = 1'b0; host_rd = hold_host;
    checks++;
    if (wr_ps2 !== 1'b1 || ps2_tx_data !== op || cmd_busy !== 1'b1)
      $display("FAIL %s first_write: wr=%0b data=%02h busy=%0b, expected wr=1 data=%02h busy=1",
               tag, wr_ps2, ps2_tx_data, cmd_busy, op);
    else passed++;
    got_done = 0;
    for (waited = 0; waited < 5000 && !got_done; waited++) begin
      @(negedge clk);
      if (waited == 0) begin
        checks++;
        if (rd_ps2_packet !== 1'b0 || host_rx_empty !== 1'b1)
          $display("FAIL %s busy_block: rd=%0b host_empty=%0b, expected rd=0 host_empty=1",
                   tag, rd_ps2_packet, host_rx_empty);
        else passed++;
      end
      if (cmd_done_tick === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done) $display("FAIL %s done_wait: no cmd_done_tick in 5000 cycles, expected one", tag);
    else passed++;
    checks++;
    if (err_code !== exp_err || cmd_err !== (exp_err != 2'b00))
      $display("FAIL %s result: err_code=%02b cmd_err=%0b, expected err_code=%02b cmd_err=%0b",
               tag, err_code, cmd_err, exp_err, (exp_err != 2'b00));
    else passed++;
    if (exp_err == 2'b01) begin
      checks++;
      if (cyc - last_idle_cyc < TIMEOUT_CYC || cyc - last_idle_cyc > TIMEOUT_CYC + 2)
        $display("FAIL %s timeout_latency: %0d cycles after TX idle, expected %0d..%0d",
                 tag, cyc - last_idle_cyc, TIMEOUT_CYC, TIMEOUT_CYC + 2);
      else passed++;
    end
    host_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_done_tick !== 1'b0 || cmd_busy !== 1'b0 || cmd_err !== (exp_err != 2'b00))
      $display("FAIL %s after_done: tick=%0b busy=%0b cmd_err=%0b, expected tick=0 busy=0 cmd_err=%0b",
               tag, cmd_done_tick, cmd_busy, cmd_err, (exp_err != 2'b00));
    else passed++;
    repeat (8) @(negedge clk);
    bad = (tx_log.size() != exp_tx.size());
    for (int i = 0; i < tx_log.size() && !bad; i++) if (tx_log[i] !== exp_tx[i]) bad = 1;
    checks++;
    if (bad) $display("FAIL %s tx_bytes: %0d writes %p, expected %0d writes %p",
                      tag, tx_log.size(), tx_log, exp_tx.size(), exp_tx);
    else passed++;
    checks++;
    if (pop_cnt - pops0 != exp_pops)
      $display("FAIL %s pops: %0d, expected %0d", tag, pop_cnt - pops0, exp_pops);
    else passed++;
    reply_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_busy !== 1'b0 || cmd_done_tick !== 1'b0 || cmd_err !== 1'b0 || err_code !== 2'b00 ||
        wr_ps2 !== 1'b0 || rd_ps2_packet !== 1'b0 || host_rx_empty !== 1'b1)
      $display("FAIL reset_outputs: busy=%0b tick=%0b err=%0b code=%02b wr=%0b rd=%0b hempty=%0b, expected 0 0 0 00 0 0 1",
               cmd_busy, cmd_done_tick, cmd_err, err_code, wr_ps2, rd_ps2_packet, host_rx_empty);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_arg();
    script = '{8'hFA};
    run_cmd("no_arg", 8'hF4, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_with_arg();
    script = '{8'hFA, 8'hFA};
    run_cmd("with_arg", 8'hF3, 1'b1, 8'h14, 0, 1'b0, 1'b0);
  endtask

  task automatic test_retry();
    script = '{8'hFE, 8'hFE, 8'hFE, 8'hFA};
    run_cmd("retry_ok", 8'hED, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    script = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
    run_cmd("retry_exhausted", 8'hED, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    script.delete();
    run_cmd("timeout", 8'hFF, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    script = '{8'hFA, 8'hFC};
    run_cmd("device_err", 8'hF3, 1'b1, 8'h28, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stale_and_host();
    script = '{8'hFA};
    rx_q.delete();
    run_cmd("stale_byte", 8'hF4, 1'b0, 8'h00, 2, 1'b1, 1'b0);
  endtask

  task automatic test_host_passthrough();
    int p0;
    @(negedge clk);
    rx_q.push_back(8'h5A); rx_q.push_back(8'h3C);
    repeat (2) @(negedge clk);
    checks++;
    if (host_rx_empty !== 1'b0 || host_rx_data !== 8'h5A)
      $display("FAIL host_head: empty=%0b data=%02h, expected empty=0 data=5a", host_rx_empty, host_rx_data);
    else passed++;
    p0 = pop_cnt;
    host_rd = 1'b1; @(negedge clk); host_rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pop_cnt - p0 != 1 || host_rx_data !== 8'h3C)
      $display("FAIL host_pop: pops=%0d data=%02h, expected pops=1 data=3c", pop_cnt - p0, host_rx_data);
    else passed++;
    host_rd = 1'b1; @(negedge clk); host_rd = 1'b0;
    repeat (2) @(negedge clk);
    p0 = pop_cnt;
    host_rd = 1'b1; #1;
    checks++;
    if (rd_ps2_packet !== 1'b0 || host_rx_empty !== 1'b1)
      $display("FAIL host_empty_rd: rd=%0b empty=%0b, expected rd=0 empty=1", rd_ps2_packet, host_rx_empty);
    else passed++;
    repeat (3) @(negedge clk);
    host_rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pop_cnt != p0) $display("FAIL host_empty_pops: %0d, expected 0", pop_cnt - p0);
    else passed++;
    rx_q.push_back(8'h77);
    repeat (2) @(negedge clk);
    script = '{8'hFA};
    run_cmd("host_at_start", 8'hF5, 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int waited;
    script = '{8'hFA};
    reply_q = script;
    @(negedge clk);
    cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (waited = 0; waited < 50 && ps2_tx_idle !== 1'b0; waited++) @(negedge clk);
    checks++;
    if (ps2_tx_idle !== 1'b0) $display("FAIL reset_mid_tx: TX never went busy, expected busy within 50 cycles");
    else passed++;
    @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if (cmd_busy !== 1'b0 || cmd_done_tick !== 1'b0 || cmd_err !== 1'b0 || err_code !== 2'b00 ||
        wr_ps2 !== 1'b0 || rd_ps2_packet !== 1'b0)
      $display("FAIL reset_mid_outputs: busy=%0b tick=%0b err=%0b code=%02b wr=%0b rd=%0b, expected all 0",
               cmd_busy, cmd_done_tick, cmd_err, err_code, wr_ps2, rd_ps2_packet);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    rx_q.delete(); reply_q.delete();
    script = '{8'hFA, 8'hFA};
    run_cmd("after_reset", 8'hF3, 1'b1, 8'h0A, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 20; n++) begin
      script.delete();
      for (int i = 0; i < 10; i++) begin
        k = $urandom_range(0, 9);
        script.push_back(k < 6 ? 8'hFA : (k < 9 ? 8'hFE : 8'hFC));
      end
      run_cmd($sformatf("random_%0d", n), 8'($urandom), 1'($urandom), 8'($urandom),
              $urandom_range(0, 2), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0;
    cmd_arg = 8'h00; host_rd = 1'b0;
    test_reset();
    test_no_arg();
    test_with_arg();
    test_retry();
    test_errors();
    test_stale_and_host();
    test_host_passthrough();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
